// File: rtl/mileage_bcd_recorder.sv
// Distance recorder: divides motion time into distance units, saturates at MAX_COUNT,
// and converts the record to packed BCD with a sequential double-dabble engine.
module mileage_bcd_recorder #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BIN_W     = 24,
    parameter int DIGITS    = 7,
    parameter int MAX_COUNT = 9_999_999
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                power_on,
    input  logic                move_en,
    input  logic                clear_record,
    output logic [BIN_W-1:0]    record_bin,
    output logic [4*DIGITS-1:0] bcd_digits,
    output logic                digits_valid,
    output logic                busy,
    output logic [1:0]          fsm_state
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [BIN_W-1:0] REC_MAX   = BIN_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIN_W-1:0]   rec_q, rec_d;
    logic               dirty_q, dirty_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;
    logic               set_dirty;
    logic [BCD_W-1:0]   adj;

    // Divider and accumulator; clear wins over a coincident tick.
    always_comb begin
        div_d     = div_q;
        rec_d     = rec_q;
        tick      = 1'b0;
        set_dirty = 1'b0;
        if (clear_record) begin
            div_d     = '0;
            rec_d     = '0;
            set_dirty = 1'b1;
        end else if (power_on && move_en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            if (tick && (rec_q < REC_MAX)) begin
                rec_d     = rec_q + BIN_W'(1);
                set_dirty = 1'b1;
            end
        end
    end

    // A change landing in the snapshot cycle keeps dirty set, forcing a follow-up pass.
    always_comb begin
        dirty_d = dirty_q;
        if (set_dirty) begin
            dirty_d = 1'b1;
        end else if (state_q == S_LOAD) begin
            dirty_d = 1'b0;
        end
    end

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d   = rec_q;
                scratch_d = '0;
                cnt_d     = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SHIFT_LAST) begin
                    // Publish together with entering DONE so the pulse and the digits align.
                    bcd_d   = scratch_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = dirty_q ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            rec_q     <= '0;
            dirty_q   <= 1'b0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            rec_q     <= rec_d;
            dirty_q   <= dirty_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign record_bin   = rec_q;
    assign bcd_digits   = bcd_q;
    assign digits_valid = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_mileage_bcd_recorder.sv
// Directed bench for mileage_bcd_recorder: expected digit values are queued as stimulus
// is driven and popped when the recorder publishes a conversion.
module tb_mileage_bcd_recorder;

    localparam int TICK_DIV  = 4;
    localparam int BIN_W     = 24;
    localparam int DIGITS    = 7;
    localparam int MAX_COUNT = 99;
    localparam int W         = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             power_on;
    logic             move_en;
    logic             clear_record;
    logic [BIN_W-1:0] record_bin;
    logic [W-1:0]     bcd_digits;
    logic             digits_valid;
    logic             busy;
    logic [1:0]       fsm_state;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    int           pulse_cnt = 0;
    int           bad_pulse = 0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] last_val = '0;
    logic [W-1:0] prev_val = '0;

    mileage_bcd_recorder #(
        .TICK_DIV (TICK_DIV),
        .BIN_W    (BIN_W),
        .DIGITS   (DIGITS),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .power_on    (power_on),
        .move_en     (move_en),
        .clear_record(clear_record),
        .record_bin  (record_bin),
        .bcd_digits  (bcd_digits),
        .digits_valid(digits_valid),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] v);
        bit ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Pulse monitor: records every publication and flags malformed ones.
    always @(negedge clk) begin
        if (digits_valid) begin
            pulse_cnt = pulse_cnt + 1;
            prev_val  = last_val;
            last_val  = bcd_digits;
            if (prev_valid || !busy || !is_bcd(bcd_digits)) bad_pulse = bad_pulse + 1;
        end
        prev_valid = digits_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pops the next expected value and waits (bounded) for a publication of it.
    task automatic wait_pulse(input string tag, input int limit);
        logic [W-1:0] exp;
        bit found;
        found = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            for (int i = 0; i < limit && !found; i++) begin
                @(negedge clk);
                if (digits_valid && bcd_digits === exp) found = 1'b1;
            end
            check(tag, {31'd0, found}, 32'd1);
        end
    endtask

    task automatic wait_shift(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fsm_state == 2'd2) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_clear();
        clear_record = 1'b1;
        exp_q.push_back(to_bcd(0));
        cyc(1);
        clear_record = 1'b0;
    endtask

    initial begin
        int p;
        int d;
        rst          = 1'b1;
        power_on     = 1'b1;
        move_en      = 1'b1;
        clear_record = 1'b0;

        // Reset holds everything at zero even while moving.
        cyc(3);
        @(negedge clk);
        check("rst_record", record_bin, 0);
        check("rst_bcd", bcd_digits, 0);
        check("rst_valid", digits_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 0);
        check("rst_no_pulse", pulse_cnt, 0);
        cyc(1);
        move_en = 1'b0;
        rst     = 1'b0;
        cyc(2);

        // Accumulation: 52 enabled clocks -> 13 units.
        move_en = 1'b1;
        exp_q.push_back(to_bcd(13));
        cyc(52);
        move_en = 1'b0;
        @(negedge clk);
        check("acc_record", record_bin, 13);
        wait_pulse("acc_pulse", 120);
        cyc(30);
        @(negedge clk);
        check("acc_bcd", bcd_digits, 32'h13);
        check("acc_idle", busy, 0);

        // Divider holds its count while the enable is low.
        do_clear();
        wait_pulse("clr1_pulse", 60);
        cyc(30);
        move_en = 1'b1;
        cyc(3);
        move_en = 1'b0;
        @(negedge clk);
        check("hold_after3", record_bin, 0);
        cyc(10);
        @(negedge clk);
        check("hold_low10", record_bin, 0);
        move_en = 1'b1;
        exp_q.push_back(to_bcd(1));
        cyc(1);
        move_en = 1'b0;
        @(negedge clk);
        check("hold_tick", record_bin, 1);
        wait_pulse("hold_pulse", 60);
        cyc(30);

        // Saturation at MAX_COUNT.
        do_clear();
        wait_pulse("clr2_pulse", 60);
        cyc(30);
        move_en = 1'b1;
        exp_q.push_back(to_bcd(MAX_COUNT));
        cyc(4 * MAX_COUNT);
        @(negedge clk);
        check("sat_reach", record_bin, MAX_COUNT);
        wait_pulse("sat_pulse", 120);
        cyc(30);
        p = pulse_cnt;
        cyc(40);
        @(negedge clk);
        check("sat_record", record_bin, MAX_COUNT);
        check("sat_bcd", bcd_digits, 32'h99);
        check("sat_no_pulse", pulse_cnt, p);
        move_en = 1'b0;

        // Coalescing: clear arrives mid-conversion of 42.
        do_clear();
        wait_pulse("clr3_pulse", 60);
        cyc(30);
        move_en = 1'b1;
        exp_q.push_back(to_bcd(41));
        cyc(4 * 41);
        move_en = 1'b0;
        @(negedge clk);
        check("coal_41", record_bin, 41);
        wait_pulse("coal_41_pulse", 120);
        cyc(30);
        p = pulse_cnt;
        move_en = 1'b1;
        cyc(4);
        move_en = 1'b0;
        @(negedge clk);
        check("coal_42", record_bin, 42);
        wait_shift("coal_enter_shift");
        cyc(5);
        do_clear();
        wait_pulse("coal_final_pulse", 100);
        d = pulse_cnt - p;
        check("coal_pulse_count", {31'd0, (d >= 1 && d <= 2)}, 32'd1);
        if (d == 2) check("coal_first_val", prev_val, 32'h42);
        cyc(30);
        @(negedge clk);
        check("coal_bcd", bcd_digits, 0);
        check("coal_record", record_bin, 0);
        check("coal_busy", busy, 0);

        // Asynchronous reset during SHIFT aborts without a publication.
        move_en = 1'b1;
        cyc(4);
        move_en = 1'b0;
        wait_shift("rstmid_enter_shift");
        cyc(3);
        #2;
        rst = 1'b1;
        p = pulse_cnt;
        #1;
        check("rstmid_record", record_bin, 0);
        check("rstmid_bcd", bcd_digits, 0);
        check("rstmid_valid", digits_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_state", fsm_state, 0);
        #3;
        rst = 1'b0;
        cyc(40);
        @(negedge clk);
        check("rstmid_no_pulse", pulse_cnt, p);

        check("pulse_wellformed", bad_pulse, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
